// File: rtl/tri_lcb_seq_pkg.sv
// Shared types for the local clock-control sequencer: lclk bus width, state
// encoding and the per-state output decode used by the FSM.
package tri_lcb_seq_pkg;

    localparam int unsigned NCLK_WIDTH = 5;
    localparam int unsigned LCLK_CLK    = 0;
    localparam int unsigned LCLK_SRESET = 1;

    typedef enum logic [2:0] {
        TRI_LCB_SEQ_SRESET  = 3'd0,
        TRI_LCB_SEQ_RUN     = 3'd1,
        TRI_LCB_SEQ_DRAIN   = 3'd2,
        TRI_LCB_SEQ_STOPPED = 3'd3,
        TRI_LCB_SEQ_RESUME  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic sreset;
        logic d1clk;
        logic d2clk;
        logic stop_ack;
    } seq_out_t;

    localparam seq_out_t SEQ_OUT_RESET = '{sreset: 1'b1, d1clk: 1'b0, d2clk: 1'b0, stop_ack: 1'b0};

    // Latch-control values presented while the FSM sits in a given state.
    function automatic seq_out_t seq_decode(seq_state_e st, logic act, logic thold);
        seq_out_t o;
        o = '0;
        case (st)
            TRI_LCB_SEQ_SRESET: begin
                o.sreset = 1'b1;
                o.d2clk  = 1'b1;
            end
            TRI_LCB_SEQ_RUN: begin
                o.d1clk = act & ~thold;
                o.d2clk = ~thold;
            end
            TRI_LCB_SEQ_DRAIN:   o.d2clk    = 1'b1;
            TRI_LCB_SEQ_STOPPED: o.stop_ack = 1'b1;
            TRI_LCB_SEQ_RESUME:  o.d2clk    = ~thold;
            default: ;
        endcase
        return o;
    endfunction

    function automatic bit cnt_fits(int unsigned val, int unsigned width);
        return (val >= 1) && (width >= 1) && (width < 32) &&
               (val <= ((32'd1 << width) - 32'd1));
    endfunction

endpackage

// File: rtl/tri_lcb_seq_if.sv
// Control/handshake bundle between a clock-stop controller and the sequencer.
interface tri_lcb_seq_if
    import tri_lcb_seq_pkg::*;
;
    logic                  act_in;
    logic                  force_act;
    logic                  thold_in;
    logic                  sreset_req;
    logic                  stop_req;
    logic                  stop_ack;
    logic                  d1clk;
    logic                  d2clk;
    logic [NCLK_WIDTH-1:0] lclk;
    logic [2:0]            seq_state;

    modport master (
        output act_in, force_act, thold_in, sreset_req, stop_req,
        input  stop_ack, d1clk, d2clk, lclk, seq_state
    );

    modport slave (
        input  act_in, force_act, thold_in, sreset_req, stop_req,
        output stop_ack, d1clk, d2clk, lclk, seq_state
    );

endinterface

// File: rtl/tri_lcb_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module tri_lcb_seq_cnt #(
    parameter int unsigned     WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tri_lcb_seq.sv
// Local clock-control sequencer: sreset sequencing, act gating and a four-phase
// clock-stop handshake for a group of tri_nlat latches.
module tri_lcb_seq
    import tri_lcb_seq_pkg::*;
#(
    parameter int unsigned SRESET_CYCLES = 4,
    parameter int unsigned STOP_DELAY    = 2,
    parameter int unsigned RESUME_DELAY  = 2,
    parameter int unsigned CNT_WIDTH     = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    tri_lcb_seq_if.slave bus
);

    if (!(cnt_fits(SRESET_CYCLES, CNT_WIDTH) && cnt_fits(STOP_DELAY, CNT_WIDTH) &&
          cnt_fits(RESUME_DELAY, CNT_WIDTH))) begin : g_bad_param
        $error("tri_lcb_seq: delay parameter outside 1..2^CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] SRESET_LOAD = CNT_WIDTH'(SRESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STOP_LOAD   = CNT_WIDTH'(STOP_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RESUME_LOAD = CNT_WIDTH'(RESUME_DELAY - 1);

    seq_state_e           r_state;
    seq_state_e           w_next;
    seq_out_t             r_out;
    seq_out_t             w_out;
    logic                 w_load;
    logic                 w_dec;
    logic [CNT_WIDTH-1:0] w_load_val;
    logic                 w_zero;

    tri_lcb_seq_cnt #(
        .WIDTH   (CNT_WIDTH),
        .RST_VAL (SRESET_LOAD)
    ) u_cnt (
        .clk        (clk),
        .rst_b      (rst_b),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= TRI_LCB_SEQ_SRESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are registered from the state being entered, so stop_ack and the
    // sreset strobe change on the same edge as the transition that causes them.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_out <= SEQ_OUT_RESET;
        end else begin
            r_out <= w_out;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_load_val = '0;

        if (bus.sreset_req) begin
            w_next     = TRI_LCB_SEQ_SRESET;
            w_load     = 1'b1;
            w_load_val = SRESET_LOAD;
        end else begin
            case (r_state)
                TRI_LCB_SEQ_SRESET: begin
                    if (w_zero) w_next = TRI_LCB_SEQ_RUN;
                    else        w_dec  = 1'b1;
                end
                TRI_LCB_SEQ_RUN: begin
                    if (bus.stop_req) begin
                        w_next     = TRI_LCB_SEQ_DRAIN;
                        w_load     = 1'b1;
                        w_load_val = STOP_LOAD;
                    end
                end
                TRI_LCB_SEQ_DRAIN: begin
                    if (w_zero) w_next = TRI_LCB_SEQ_STOPPED;
                    else        w_dec  = 1'b1;
                end
                TRI_LCB_SEQ_STOPPED: begin
                    if (!bus.stop_req) begin
                        w_next     = TRI_LCB_SEQ_RESUME;
                        w_load     = 1'b1;
                        w_load_val = RESUME_LOAD;
                    end
                end
                TRI_LCB_SEQ_RESUME: begin
                    if (w_zero) w_next = TRI_LCB_SEQ_RUN;
                    else        w_dec  = 1'b1;
                end
                default: begin
                    w_next     = TRI_LCB_SEQ_SRESET;
                    w_load     = 1'b1;
                    w_load_val = SRESET_LOAD;
                end
            endcase
        end

        w_out = seq_decode(w_next, bus.act_in | bus.force_act, bus.thold_in);
    end

    assign bus.d1clk     = r_out.d1clk;
    assign bus.d2clk     = r_out.d2clk;
    assign bus.stop_ack  = r_out.stop_ack;
    assign bus.seq_state = r_state;
    assign bus.lclk      = {{(NCLK_WIDTH - 2){1'b0}}, r_out.sreset, clk};

endmodule
